delivery_ctrl: RTL and testbench

Parametrised top-level sequencer for the delivery robot. It generalises the cargo colour width and adds a debounced hall input, a confirm/error/timeout buzz mode, a delivery counter and an optional send timeout. It sits between the sensor front-end (hall, colour modules) and the actuator/feedback modules (tracking, u-turn, buzzer, SSD driver). It decides when to track, turn and buzz, and reports a status code for display.

---
 rtl/delivery_pkg.sv | 53 +++++
 rtl/delivery_ctrl_hall_debounce.sv | 58 +++++
 rtl/delivery_ctrl.sv | 138 +++++++++++++
 tb/tb_delivery_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/delivery_pkg.sv
// delivery_pkg: shared constants for the delivery robot sequencer.
// Holds one-hot state encodings, display status codes and buzzer modes,
// plus decode helpers used by delivery_ctrl.
package delivery_pkg;

  localparam int STATE_W = 7;

  localparam logic [STATE_W-1:0] S_IDLE    = 7'b000_0001;
  localparam logic [STATE_W-1:0] S_NOCOLOR = 7'b000_0010;
  localparam logic [STATE_W-1:0] S_SEND    = 7'b000_0100;
  localparam logic [STATE_W-1:0] S_ARRIVED = 7'b000_1000;
  localparam logic [STATE_W-1:0] S_UTURN   = 7'b001_0000;
  localparam logic [STATE_W-1:0] S_RETURN  = 7'b010_0000;
  localparam logic [STATE_W-1:0] S_EOT     = 7'b100_0000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_NOCOLOR = 3'd1;
  localparam logic [2:0] ST_SEND    = 3'd2;
  localparam logic [2:0] ST_ARRIVED = 3'd3;
  localparam logic [2:0] ST_UTURN   = 3'd4;
  localparam logic [2:0] ST_RETURN  = 3'd5;
  localparam logic [2:0] ST_EOT     = 3'd6;

  localparam logic [1:0] BUZZ_NONE    = 2'd0;
  localparam logic [1:0] BUZZ_CONFIRM = 2'd1;
  localparam logic [1:0] BUZZ_ERROR   = 2'd2;
  localparam logic [1:0] BUZZ_TIMEOUT = 2'd3;

  // Display code for a one-hot state.
  function automatic logic [2:0] state_status(input logic [STATE_W-1:0] s);
    case (s)
      S_NOCOLOR: return ST_NOCOLOR;
      S_SEND:    return ST_SEND;
      S_ARRIVED: return ST_ARRIVED;
      S_UTURN:   return ST_UTURN;
      S_RETURN:  return ST_RETURN;
      S_EOT:     return ST_EOT;
      default:   return ST_IDLE;
    endcase
  endfunction

  // Buzzer mode for a one-hot state; EOT reports a timeout distinctly.
  function automatic logic [1:0] state_buzz(input logic [STATE_W-1:0] s,
                                            input logic by_timeout);
    case (s)
      S_NOCOLOR: return BUZZ_ERROR;
      S_ARRIVED: return BUZZ_CONFIRM;
      S_EOT:     return by_timeout ? BUZZ_TIMEOUT : BUZZ_ERROR;
      default:   return BUZZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/delivery_ctrl_hall_debounce.sv
// hall_debounce: synchronises the raw hall sensor, requires the level to
// hold for HALL_DB cycles before accepting a change, and emits a one-cycle
// pulse on each accepted rising edge.
module hall_debounce #(
  parameter int HALL_DB = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic hall,
  output logic hall_evt
);

  localparam int CW = (HALL_DB > 1) ? $clog2(HALL_DB) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous sensor input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= hall;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for HALL_DB samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(HALL_DB - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising-edge pulse of the debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_d  <= 1'b0;
      hall_evt <= 1'b0;
    end else begin
      level_d  <= level;
      hall_evt <= level & ~level_d;
    end
  end

endmodule

// File: rtl/delivery_ctrl.sv
// delivery_ctrl: top-level sequencer for the delivery robot.
// Decides when to track, turn and buzz, counts deliveries and reports a
// status code. Optional SEND timeout enabled by macro DELIVERY_TIMEOUT_EN.
module delivery_ctrl
  import delivery_pkg::*;
#(
  parameter int COLOR_W      = 2,
  parameter int HALL_DB      = 50000,
  parameter int SEND_TIMEOUT = 500000000,
  parameter int TO_W         = 29,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hall,
  input  logic [COLOR_W-1:0] object_color,
  input  logic [COLOR_W-1:0] station_color,
  input  logic               station_valid,
  input  logic               end_of_track,
  input  logic               uturn_finished,
  input  logic               buzz_finished,
  output logic               en_tracking,
  output logic               en_uturn,
  output logic               en_buzz,
  output logic [1:0]         buzz_mode,
  output logic [2:0]         status,
  output logic [COLOR_W-1:0] cargo_color,
  output logic [CNT_W-1:0]   delivered_cnt
);

  logic               hall_evt;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic               first_cycle;
  logic               returning;
  logic               eot_by_to;
  logic               next_by_to;
  logic               timeout_hit;
  logic               match;

  hall_debounce #(.HALL_DB(HALL_DB)) u_hall (
    .clk      (clk),
    .rst      (rst),
    .hall     (hall),
    .hall_evt (hall_evt)
  );

  assign match = station_valid && (station_color == cargo_color);

`ifdef DELIVERY_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Count cycles spent in SEND, restarting from zero on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                to_cnt <= '0;
    else if (state != S_SEND) to_cnt <= '0;
    else                     to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_SEND) && (to_cnt == TO_W'(SEND_TIMEOUT - 1));
`else
  // Timeout parameters have no hardware in this build.
  logic [TO_W-1:0] unused_timeout;
  assign unused_timeout = TO_W'(SEND_TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state decision; feedback pulses are ignored in a state's first cycle.
  always_comb begin
    next_state = state;
    next_by_to = 1'b0;
    case (state)
      S_IDLE:
        if (hall_evt) next_state = (object_color == '0) ? S_NOCOLOR : S_SEND;
      S_NOCOLOR:
        if (buzz_finished && !first_cycle) next_state = S_IDLE;
      S_SEND:
        if (match) next_state = S_ARRIVED;
        else if (end_of_track) next_state = S_EOT;
        else if (timeout_hit) begin
          next_state = S_EOT;
          next_by_to = 1'b1;
        end
      S_ARRIVED:
        if (hall_evt) next_state = S_UTURN;
      S_UTURN:
        if (uturn_finished && !first_cycle) next_state = returning ? S_IDLE : S_RETURN;
      S_RETURN:
        if (end_of_track) next_state = S_UTURN;
      S_EOT: begin
        next_by_to = eot_by_to;
        if (buzz_finished && !first_cycle) next_state = S_UTURN;
      end
      default:
        next_state = S_IDLE;
    endcase
  end

  // State, bookkeeping and outputs all registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      first_cycle   <= 1'b0;
      eot_by_to     <= 1'b0;
      returning     <= 1'b0;
      en_tracking   <= 1'b0;
      en_uturn      <= 1'b0;
      en_buzz       <= 1'b0;
      buzz_mode     <= BUZZ_NONE;
      status        <= ST_IDLE;
      cargo_color   <= '0;
      delivered_cnt <= '0;
    end else begin
      state       <= next_state;
      first_cycle <= (next_state != state);
      eot_by_to   <= next_by_to;
      en_tracking <= (next_state == S_SEND) || (next_state == S_RETURN);
      en_uturn    <= (next_state == S_UTURN);
      en_buzz     <= (next_state == S_NOCOLOR) || (next_state == S_ARRIVED) ||
                     (next_state == S_EOT);
      buzz_mode   <= state_buzz(next_state, next_by_to);
      status      <= state_status(next_state);

      if (next_state == S_IDLE)        returning <= 1'b0;
      else if (next_state == S_RETURN) returning <= 1'b1;

      if (state == S_IDLE && next_state == S_SEND) begin
        cargo_color <= object_color;
      end else if (state == S_ARRIVED && next_state == S_UTURN) begin
        cargo_color <= '0;
        if (delivered_cnt != '1) delivered_cnt <= delivered_cnt + 1'b1;
      end else if (state == S_EOT && next_state == S_UTURN) begin
        cargo_color <= '0;
      end
    end
  end

endmodule

// File: tb/tb_delivery_ctrl.sv
// tb_delivery_ctrl: table-driven directed bench for delivery_ctrl with
// HALL_DB=4, SEND_TIMEOUT=100 and a 2-bit delivery counter.
module tb_delivery_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hall = 1'b0;
  logic [1:0] object_color = '0;
  logic [1:0] station_color = '0;
  logic       station_valid = 1'b0;
  logic       end_of_track = 1'b0;
  logic       uturn_finished = 1'b0;
  logic       buzz_finished = 1'b0;
  logic       en_tracking;
  logic       en_uturn;
  logic       en_buzz;
  logic [1:0] buzz_mode;
  logic [2:0] status;
  logic [1:0] cargo_color;
  logic [1:0] delivered_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic       h;
    logic [1:0] obj;
    logic [1:0] sc;
    logic       sv;
    logic       eot;
    logic       uf;
    logic       bf;
    int         cycles;
    logic [2:0] st;
    logic       tr;
    logic       ut;
    logic       bz;
    logic [1:0] mode;
    logic [1:0] cargo;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  delivery_ctrl #(
    .COLOR_W(2), .HALL_DB(4), .SEND_TIMEOUT(100), .TO_W(8), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .hall(hall),
    .object_color(object_color), .station_color(station_color),
    .station_valid(station_valid), .end_of_track(end_of_track),
    .uturn_finished(uturn_finished), .buzz_finished(buzz_finished),
    .en_tracking(en_tracking), .en_uturn(en_uturn), .en_buzz(en_buzz),
    .buzz_mode(buzz_mode), .status(status), .cargo_color(cargo_color),
    .delivered_cnt(delivered_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic h, input logic [1:0] obj,
                              input logic [1:0] sc, input logic sv, input logic eot,
                              input logic uf, input logic bf, input int cycles,
                              input logic [2:0] st, input logic tr, input logic ut,
                              input logic bz, input logic [1:0] mode,
                              input logic [1:0] cargo, input logic [1:0] cnt);
    vec_t v;
    v.name = name; v.h = h; v.obj = obj; v.sc = sc; v.sv = sv; v.eot = eot;
    v.uf = uf; v.bf = bf; v.cycles = cycles; v.st = st; v.tr = tr; v.ut = ut;
    v.bz = bz; v.mode = mode; v.cargo = cargo; v.cnt = cnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    hall = v.h; object_color = v.obj; station_color = v.sc; station_valid = v.sv;
    end_of_track = v.eot; uturn_finished = v.uf; buzz_finished = v.bf;
    repeat (v.cycles) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v);
    logic [11:0] act, exp;
    act = {status, en_tracking, en_uturn, en_buzz, buzz_mode, cargo_color, delivered_cnt};
    exp = {v.st, v.tr, v.ut, v.bz, v.mode, v.cargo, v.cnt};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got st=%0d tr=%b ut=%b bz=%b mode=%0d cargo=%0d cnt=%0d, want st=%0d tr=%b ut=%b bz=%b mode=%0d cargo=%0d cnt=%0d",
               v.name, status, en_tracking, en_uturn, en_buzz, buzz_mode, cargo_color,
               delivered_cnt, v.st, v.tr, v.ut, v.bz, v.mode, v.cargo, v.cnt);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic doDelivery(input logic [1:0] prev_cnt, input logic [1:0] exp_cnt);
    vec_t d[$];
    d.push_back(mk("sat_send",     1,1,0,0,0,0,0,10, 2,1,0,0,0,1,prev_cnt));
    d.push_back(mk("sat_arrive",   0,1,1,1,0,0,0,1,  3,0,0,1,1,1,prev_cnt));
    d.push_back(mk("sat_wait",     0,1,0,0,0,0,0,8,  3,0,0,1,1,1,prev_cnt));
    d.push_back(mk("sat_remove",   1,1,0,0,0,0,0,10, 4,0,1,0,0,0,exp_cnt));
    d.push_back(mk("sat_ut1",      0,0,0,0,0,1,0,1,  5,1,0,0,0,0,exp_cnt));
    d.push_back(mk("sat_ret_eot",  0,0,0,0,1,0,0,1,  4,0,1,0,0,0,exp_cnt));
    d.push_back(mk("sat_home",     0,0,0,0,0,1,0,2,  0,0,0,0,0,0,exp_cnt));
    d.push_back(mk("sat_settle",   0,0,0,0,0,0,0,8,  0,0,0,0,0,0,exp_cnt));
    foreach (d[i]) begin
      applyStimulus(d[i]);
      checkOutput(d[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;

    // Delivery with cargo 2, including the first-cycle feedback rule.
    vecs.push_back(mk("dlv_send",       1,2,0,0,0,0,0,10, 2,1,0,0,0,2,0));
    vecs.push_back(mk("dlv_arrive",     0,2,2,1,0,0,0,1,  3,0,0,1,1,2,0));
    vecs.push_back(mk("dlv_wait",       0,2,0,0,0,0,0,8,  3,0,0,1,1,2,0));
    vecs.push_back(mk("dlv_remove",     1,2,0,0,0,0,0,10, 4,0,1,0,0,0,1));
    vecs.push_back(mk("dlv_ut1",        0,0,0,0,0,1,0,1,  5,1,0,0,0,0,1));
    vecs.push_back(mk("dlv_ret_eot",    0,0,0,0,1,0,0,1,  4,0,1,0,0,0,1));
    vecs.push_back(mk("dlv_ut2_first",  0,0,0,0,0,1,0,1,  4,0,1,0,0,0,1));
    vecs.push_back(mk("dlv_home",       0,0,0,0,0,1,0,1,  0,0,0,0,0,0,1));
    vecs.push_back(mk("dlv_settle",     0,0,0,0,0,0,0,8,  0,0,0,0,0,0,1));
    // No colour loaded.
    vecs.push_back(mk("nc_enter",       1,0,0,0,0,0,0,10, 1,0,0,1,2,0,1));
    vecs.push_back(mk("nc_done",        0,0,0,0,0,0,1,1,  0,0,0,0,0,0,1));
    vecs.push_back(mk("nc_settle",      0,0,0,0,0,0,0,8,  0,0,0,0,0,0,1));
    // Wrong station, then end of track.
    vecs.push_back(mk("ws_send",        1,3,0,0,0,0,0,10, 2,1,0,0,0,3,1));
    vecs.push_back(mk("ws_wrong",       0,3,1,1,0,0,0,3,  2,1,0,0,0,3,1));
    vecs.push_back(mk("ws_eot",         0,3,0,0,1,0,0,1,  6,0,0,1,2,3,1));
    vecs.push_back(mk("ws_buzz_first",  0,3,0,0,0,0,1,1,  6,0,0,1,2,3,1));
    vecs.push_back(mk("ws_buzz_done",   0,3,0,0,0,0,1,1,  4,0,1,0,0,0,1));
    vecs.push_back(mk("ws_ut_first",    0,0,0,0,0,1,0,1,  4,0,1,0,0,0,1));
    vecs.push_back(mk("ws_ut_done",     0,0,0,0,0,1,0,1,  5,1,0,0,0,0,1));
    vecs.push_back(mk("ws_ret_eot",     0,0,0,0,1,0,0,1,  4,0,1,0,0,0,1));
    vecs.push_back(mk("ws_home",        0,0,0,0,0,1,0,2,  0,0,0,0,0,0,1));
    vecs.push_back(mk("ws_settle",      0,0,0,0,0,0,0,8,  0,0,0,0,0,0,1));
    // Hall glitch shorter than the debounce window.
    vecs.push_back(mk("glitch_pulse",   1,2,0,0,0,0,0,3,  0,0,0,0,0,0,1));
    vecs.push_back(mk("glitch_settle",  0,2,0,0,0,0,0,10, 0,0,0,0,0,0,1));
    // Match and end_of_track in the same cycle.
    vecs.push_back(mk("sim_send",       1,2,0,0,0,0,0,10, 2,1,0,0,0,2,1));
    vecs.push_back(mk("sim_both",       0,2,2,1,1,0,0,1,  3,0,0,1,1,2,1));
    vecs.push_back(mk("sim_wait",       0,2,0,0,0,0,0,8,  3,0,0,1,1,2,1));
    vecs.push_back(mk("sim_remove",     1,2,0,0,0,0,0,10, 4,0,1,0,0,0,2));
    vecs.push_back(mk("sim_ut1",        0,0,0,0,0,1,0,1,  5,1,0,0,0,0,2));
    vecs.push_back(mk("sim_ret_eot",    0,0,0,0,1,0,0,1,  4,0,1,0,0,0,2));
    vecs.push_back(mk("sim_home",       0,0,0,0,0,1,0,2,  0,0,0,0,0,0,2));
    vecs.push_back(mk("sim_settle",     0,0,0,0,0,0,0,8,  0,0,0,0,0,0,2));

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput(mk("reset_state", 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Counter saturates at 3 while deliveries still complete.
    doDelivery(2'd2, 2'd3);
    doDelivery(2'd3, 2'd3);

    // SEND with no further stimulus.
    hall = 1'b1; object_color = 2'd2;
    k = 0;
    while (status !== 3'd2 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checkValue("to_send_entry", int'(status), 2);
    hall = 1'b0;
`ifdef DELIVERY_TIMEOUT_EN
    k = 0;
    while (status === 3'd2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkValue("to_cycles", k, 100);
    checkOutput(mk("to_eot", 0,2,0,0,0,0,0,0, 6,0,0,1,3,2,3));
`else
    repeat (1000) @(negedge clk);
    checkOutput(mk("to_hold", 0,2,0,0,0,0,0,0, 2,1,0,0,0,2,3));
`endif

    // Reset from wherever the timeout test left us, then reset mid-SEND.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput(mk("rst_recover", 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    applyStimulus(mk("rst_send", 1,1,0,0,0,0,0,10, 2,1,0,0,0,1,0));
    checkOutput(mk("rst_send", 1,1,0,0,0,0,0,10, 2,1,0,0,0,1,0));
    rst = 1'b0; hall = 1'b0;
    #1;
    checkOutput(mk("rst_async", 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput(mk("rst_idle", 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
